clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run-control and configuration controller for a programmable counter-based clock divider (generalised decade counter/divide-by-N with duty control).
- Accepts divide-ratio and high-time configuration over a valid/ready handshake, validates it and applies it glitch-free only at period boundaries.
- Sequences start/stop so the divided output never produces a runt period.
- Sits between a register/control interface and the divided-clock consumers.

Parameters:
- CNT_W, 8, width of counter and config fields
- DEFAULT_DIV, 10, divide ratio loaded at reset (must be >= 2)
- DEFAULT_HIGH, 5, high-time in cycles loaded at reset (1..DEFAULT_DIV-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin dividing
- stop  in  1  request to stop after the current period
- cfg_valid  in  1  config offered
- cfg_ready  out  1  controller can accept config
- cfg_div  in  CNT_W  requested divide ratio N
- cfg_high  in  CNT_W  requested high-time H
- cfg_err  out  1  1-cycle pulse: accepted config was invalid and discarded
- clk_div  out  1  divided output (registered)
- count  out  CNT_W  current phase counter
- period_done  out  1  1-cycle pulse on every counter wrap
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset values: count=0, clk_div=0, period_done=0, cfg_err=0, busy=0, state=IDLE, div_r=DEFAULT_DIV, high_r=DEFAULT_HIGH, pend_vld=0.
- Reset asserted mid-operation returns everything to the reset values next edge. Pending config is discarded.
- States: IDLE, RUN, DRAIN. busy = (state != IDLE).
- Handshake:
  - cfg_ready = !pend_vld (combinational).
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_valid may be held; fields must be stable while cfg_valid & !cfg_ready.
- Validity: 2 <= cfg_div and 1 <= cfg_high <= cfg_div-1. An invalid transfer completes the handshake, pulses cfg_err the next cycle and changes nothing.
- Applying config:
  - In IDLE, a valid transfer loads div_r/high_r next cycle.
  - In RUN/DRAIN, a valid transfer stores to the shadow registers and sets pend_vld. The shadow loads into div_r/high_r on the next wrap, and pend_vld clears on that same edge.
- Counting (RUN, DRAIN):
  - count increments by 1 each cycle.
  - When count == div_r-1 the counter wraps to 0 and period_done = 1 that next cycle.
- Output: in RUN/DRAIN, clk_div <= (count < high_r). clk_div therefore lags count by one cycle. clk_div is 0 in IDLE.
- Transitions:
  - IDLE --start--> RUN: count=0 at the following edge, so first clk_div=1 one cycle later.
  - RUN --stop--> DRAIN.
  - DRAIN --wrap--> IDLE: on the wrap edge count=0, then clk_div=0 on the next edge. Any pending config is applied on that exit edge.
- Simultaneous and ignored events:
  - stop in IDLE, start outside IDLE, and stop in DRAIN are ignored.
  - start & stop together in IDLE: stay IDLE. In RUN: go to DRAIN (stop wins).
- Wrap and config in the same cycle: the incoming transfer (pend_vld=0) goes to the shadow register and waits for the following wrap. It is not applied at this wrap.
- count never exceeds div_r-1. A new smaller div_r only takes effect at a wrap, so there is no overflow case.

Decomposition:
- Package clk_div_pkg:
  - state enum typedef (IDLE, RUN, DRAIN)
  - MIN_DIV=2 constant
  - config validity function
- Sub-module div_counter_core:
  - Holds count and clk_div.
  - Inputs: en, div, high.
  - Outputs: count, clk_div, wrap.
  - The controller owns the FSM, shadow registers and handshake.

Test Plan:
- Reset release, start pulse with defaults -> busy=1; clk_div pattern 5 high/5 low; period_done every 10 cycles; count 0..9.
- While RUN, transfer div=4, high=1 mid-period -> cfg_ready=0 until the next wrap; current 10-cycle period completes intact; then 1 high/3 low, period 4.
- cfg_div=1 or cfg_high=0 or cfg_high=cfg_div -> cfg_err single pulse; div_r/high_r unchanged; output pattern unchanged.
- stop at count=3 -> DRAIN; counting continues to 9; wrap to IDLE; clk_div=0; busy=0; no runt high pulse.
- start & stop in the same cycle while IDLE -> remains IDLE. In RUN -> DRAIN. A second config while pend_vld=1 -> cfg_ready=0, transfer stalls until the wrap.
- rst asserted mid-period with pend_vld=1 -> next cycle all reset values; pending config lost; a subsequent start uses 10/5.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_ctrl divider controller.
package clk_div_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_e;

   localparam int unsigned MIN_DIV = 2;

   // A config is usable only if both the high and the low phase last at least one cycle.
   function automatic logic cfg_ok(input int unsigned div, input int unsigned high);
      return (div >= MIN_DIV) && (high >= 1) && (high <= div - 1);
   endfunction

endpackage

// File: rtl/div_counter_core.sv
// Phase counter and registered divided-clock output; free-runs only while en is high.
module div_counter_core #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] high,
   output logic [CNT_W-1:0] count,
   output logic             clk_div,
   output logic             wrap
);

   assign wrap = en && (count == div - CNT_W'(1));

   // Holding count at 0 while disabled lets a start begin a full period immediately.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count   <= '0;
         clk_div <= 1'b0;
      end else begin
         clk_div <= (count < high);
         count   <= wrap ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run control, config handshake and glitch-free config application for the clock divider.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned DEFAULT_DIV  = 10,
   parameter int unsigned DEFAULT_HIGH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             cfg_err,
   output logic             clk_div,
   output logic [CNT_W-1:0] count,
   output logic             period_done,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] div_r, high_r;
   logic [CNT_W-1:0] shd_div, shd_high;
   logic             pend_vld;
   logic             wrap;
   logic             xfer;
   logic             cfg_good;

   assign cfg_ready = !pend_vld;
   assign xfer      = cfg_valid && cfg_ready;
   assign cfg_good  = cfg_ok(32'(cfg_div), 32'(cfg_high));
   assign busy      = (state_q != StIdle);

   div_counter_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .en      (busy),
      .div     (div_r),
      .high    (high_r),
      .count   (count),
      .clk_div (clk_div),
      .wrap    (wrap)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start && !stop) state_d = StRun;
         StRun:   if (stop) state_d = StDrain;
         StDrain: if (wrap) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         div_r       <= CNT_W'(DEFAULT_DIV);
         high_r      <= CNT_W'(DEFAULT_HIGH);
         shd_div     <= '0;
         shd_high    <= '0;
         pend_vld    <= 1'b0;
         cfg_err     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_err     <= xfer && !cfg_good;
         period_done <= wrap;
         if (state_q == StIdle) begin
            // A transfer caught on the final drain wrap is still pending here; apply it now.
            if (pend_vld) begin
               div_r    <= shd_div;
               high_r   <= shd_high;
               pend_vld <= 1'b0;
            end else if (xfer && cfg_good) begin
               div_r  <= cfg_div;
               high_r <= cfg_high;
            end
         end else begin
            if (wrap && pend_vld) begin
               div_r    <= shd_div;
               high_r   <= shd_high;
               pend_vld <= 1'b0;
            end
            // xfer implies pend_vld was clear, so this never collides with the apply above.
            if (xfer && cfg_good) begin
               shd_div  <= cfg_div;
               shd_high <= cfg_high;
               pend_vld <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-level reference model feeds expectation queues.
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, stop, cfg_valid;
   logic       cfg_ready, cfg_err, clk_div, period_done, busy;
   logic [7:0] cfg_div, cfg_high, count;

   always #5 clk = ~clk;

   clk_div_ctrl #(
      .CNT_W        (8),
      .DEFAULT_DIV  (10),
      .DEFAULT_HIGH (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_div     (cfg_div),
      .cfg_high    (cfg_high),
      .cfg_err     (cfg_err),
      .clk_div     (clk_div),
      .count       (count),
      .period_done (period_done),
      .busy        (busy)
   );

   typedef struct {
      int len;
      int hi;
   } per_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   per_t exp_per[$];
   int   exp_err[$];

   // Reference model: 0 idle, 1 run, 2 drain; phase is the position inside the current period.
   int m_state, m_ph, m_div, m_high, m_pv, m_sdiv, m_shigh;

   int off_v, off_d, off_h;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_ph    = 0;
      m_div   = 10;
      m_high  = 5;
      m_pv    = 0;
      m_sdiv  = 0;
      m_shigh = 0;
      exp_per.delete();
      exp_err.delete();
   endtask

   task automatic model_step(input int st, input int sp, input int v, input int d, input int h);
      int xfer;
      int ok;
      int wr;
      xfer = (v != 0) && (m_pv == 0);
      ok   = (d >= 2) && (h >= 1) && (h <= d - 1);
      wr   = (m_state != 0) && (m_ph == m_div - 1);
      if (xfer && !ok) exp_err.push_back(cyc + 1);
      if (m_state == 0) begin
         if (m_pv != 0) begin
            m_div  = m_sdiv;
            m_high = m_shigh;
            m_pv   = 0;
         end else if (xfer && ok) begin
            m_div  = d;
            m_high = h;
         end
         if (st != 0 && sp == 0) begin
            m_state = 1;
            m_ph    = 0;
            exp_per.push_back('{len: m_div, hi: m_high});
         end
      end else begin
         if (wr) begin
            m_ph = 0;
            if (m_pv != 0) begin
               m_div  = m_sdiv;
               m_high = m_shigh;
               m_pv   = 0;
            end
         end else begin
            m_ph++;
         end
         if (xfer && ok) begin
            m_sdiv  = d;
            m_shigh = h;
            m_pv    = 1;
         end
         if (m_state == 1 && sp != 0) m_state = 2;
         else if (m_state == 2 && wr) m_state = 0;
         if (wr && m_state != 0) exp_per.push_back('{len: m_div, hi: m_high});
      end
   endtask

   task automatic cyc_step(input int st, input int sp, input int v, input int d, input int h);
      start     = (st != 0);
      stop      = (sp != 0);
      cfg_valid = (v != 0);
      cfg_div   = 8'(d);
      cfg_high  = 8'(h);
      check("cfg_ready", int'(cfg_ready), int'(m_pv == 0));
      check("busy", int'(busy), int'(m_state != 0));
      check("count", int'(count), m_ph);
      model_step(st, sp, v, d, h);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_step(0, 0, 0, 0, 0);
   endtask

   // Holds cfg_valid with stable fields until the transfer is taken.
   task automatic send_cfg(input int d, input int h);
      int done;
      done = 0;
      for (int i = 0; i < 40 && done == 0; i++) begin
         done = (m_pv == 0);
         cyc_step(0, 0, 1, d, h);
      end
      check("cfg_accept_timeout", done, 1);
   endtask

   task automatic run_until_ph(input int target);
      int n;
      n = 0;
      while (m_ph != target && n < 40) begin
         cyc_step(0, 0, 0, 0, 0);
         n++;
      end
      check("reach_phase_timeout", int'(m_ph == target), 1);
   endtask

   task automatic run_until_idle();
      int n;
      n = 0;
      while (m_state != 0 && n < 300) begin
         cyc_step(0, 0, 0, 0, 0);
         n++;
      end
      check("drain_timeout", int'(m_state == 0), 1);
   endtask

   task automatic check_reset_vals();
      check("rst_count", int'(count), 0);
      check("rst_clk_div", int'(clk_div), 0);
      check("rst_period_done", int'(period_done), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cfg_ready", int'(cfg_ready), 1);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      off_v = 0;
      check_reset_vals();
   endtask

   // Monitor: rebuilds each period from the output waveform and checks pulses against queues.
   logic prev_busy = 1'b0;
   int   len_acc   = 0;
   int   hi_acc    = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (cfg_err) begin
            if (exp_err.size() == 0) check("cfg_err_unexpected", 1, 0);
            else check("cfg_err_cycle", cyc, exp_err.pop_front());
         end
         if (prev_busy) begin
            len_acc++;
            hi_acc += int'(clk_div);
         end
         if (period_done) begin
            if (exp_per.size() == 0) begin
               check("period_unexpected", len_acc, 0);
            end else begin
               per_t p;
               p = exp_per.pop_front();
               check("period_len", len_acc, p.len);
               check("period_high", hi_acc, p.hi);
            end
            len_acc = 0;
            hi_acc  = 0;
         end
         if (!busy) begin
            len_acc = 0;
            hi_acc  = 0;
            if (!prev_busy) check("clk_div_idle", int'(clk_div), 0);
         end
         prev_busy = busy;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      cfg_high  = '0;
      off_v     = 0;
      off_d     = 0;
      off_h     = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_reset_vals();
      mon_en = 1'b1;

      // Defaults: 5 high / 5 low.
      cyc_step(1, 0, 0, 0, 0);
      idle(25);
      // Mid-period reconfig to 1 high / 3 low, applied at the next wrap.
      send_cfg(4, 1);
      idle(20);
      // Invalid configs: each should pulse cfg_err and change nothing.
      send_cfg(1, 1);
      send_cfg(6, 0);
      send_cfg(5, 5);
      idle(12);
      // Back to 10/5, then stop mid-period and drain.
      send_cfg(10, 5);
      idle(12);
      run_until_ph(3);
      cyc_step(0, 1, 0, 0, 0);
      run_until_idle();
      idle(3);
      // start & stop together: stays idle; in run it drains.
      cyc_step(1, 1, 0, 0, 0);
      idle(2);
      cyc_step(1, 0, 0, 0, 0);
      idle(3);
      cyc_step(1, 1, 0, 0, 0);
      run_until_idle();
      // Second config stalls while the first is pending.
      cyc_step(1, 0, 0, 0, 0);
      idle(2);
      send_cfg(6, 2);
      send_cfg(3, 1);
      idle(20);
      // Reset with a pending config; restart must use the defaults.
      send_cfg(8, 3);
      do_reset();
      cyc_step(1, 0, 0, 0, 0);
      idle(25);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int st;
         int sp;
         int acc;
         if ($urandom_range(0, 799) == 0) begin
            do_reset();
         end else begin
            if (off_v == 0 && $urandom_range(0, 9) == 0) begin
               off_v = 1;
               off_d = int'($urandom_range(0, 12));
               off_h = int'($urandom_range(0, off_d + 1));
            end
            st  = int'($urandom_range(0, 14) == 0);
            sp  = int'($urandom_range(0, 29) == 0);
            acc = (off_v != 0) && (m_pv == 0);
            cyc_step(st, sp, off_v, off_d, off_h);
            if (acc) off_v = 0;
         end
      end

      cyc_step(0, 1, 0, 0, 0);
      run_until_idle();
      idle(4);
      check("period_queue_empty", exp_per.size(), 0);
      check("err_queue_empty", exp_err.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
